// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath width, the HALT opcode and the
// fetch state encoding used by the fetch unit.
package cpu_pkg;

  localparam int WIDTH_DEFAULT = 16;

  // Instruction opcode lives in the top nibble of the instruction word.
  localparam logic [3:0] OP_HALT = 4'hF;

  // Fetch state encoding.
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

endpackage

// File: rtl/pc_reg.sv
// Program counter register. On load it takes either the redirect target or
// PC+1 (wrapping modulo 2^WIDTH); otherwise it holds.
module pc_reg
  import cpu_pkg::*;
#(
  parameter int               WIDTH    = WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             sel_target,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc
);

  localparam logic [WIDTH-1:0] PC_STEP = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] pc_next;

  // Two-way next-PC selection: redirect target or sequential increment.
  always_comb begin
    pc_next = sel_target ? target : (pc + PC_STEP);
  end

  // PC storage, reset straight to the boot address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one memory read at a time from PC, holds the
// returned instruction until decode accepts it, redirects on a taken branch
// and stops permanently (until reset) once a HALT instruction is accepted.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int               WIDTH    = WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_data,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic             halted
);

  logic [1:0]       state;
  logic [WIDTH-1:0] pc;
  logic             pc_load;
  logic             pc_sel_target;
  logic             instr_is_halt;

  // A redirect is honoured everywhere except HALTED; a completed read bumps PC.
  always_comb begin
    pc_sel_target = br_taken && (state != S_HALTED);
    pc_load       = pc_sel_target || ((state == S_REQ) && imem_ack);
    instr_is_halt = (instr[WIDTH-1 -: 4] == OP_HALT);
  end

  pc_reg #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (pc_load),
    .sel_target (pc_sel_target),
    .target     (br_target),
    .pc         (pc)
  );

  // Outputs derived purely from state so reset clears them immediately.
  always_comb begin
    imem_req  = (state == S_REQ);
    imem_addr = pc;
    halted    = (state == S_HALTED);
  end

  // Fetch sequencing; a branch beats any same-cycle ack or decode accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!br_taken) begin
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (br_taken) begin
            state       <= S_IDLE;
            instr_valid <= 1'b0;
          end else if (imem_ack) begin
            instr       <= imem_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (br_taken) begin
            state       <= S_IDLE;
            instr_valid <= 1'b0;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= instr_is_halt ? S_HALTED : S_REQ;
          end
        end
        default: begin
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// transaction stream checked against a transaction-level expectation model.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        br_taken = 1'b0;
  logic [15:0] br_target = '0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = '0;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        halted;

  // Second instance booting at the top of the address space.
  logic        imem_req2;
  logic [15:0] imem_addr2;
  logic        imem_ack2 = 1'b0;
  logic [15:0] imem_data2 = '0;
  logic [15:0] instr2;
  logic [15:0] instr_pc2;
  logic        instr_valid2;
  logic        instr_ready2 = 1'b0;
  logic        halted2;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_pc;

  always #5 clk = ~clk;

  fetch_unit #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .br_taken(br_taken), .br_target(br_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .halted(halted)
  );

  fetch_unit #(.WIDTH(16), .RESET_PC(16'hFFFF)) dut_top (
    .clk(clk), .rst(rst), .br_taken(br_taken), .br_target(br_target),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2),
    .imem_data(imem_data2), .instr(instr2), .instr_pc(instr_pc2),
    .instr_valid(instr_valid2), .instr_ready(instr_ready2), .halted(halted2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Advance one clock; inputs and outputs are handled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req"},    {31'b0, imem_req},    32'd0);
    chk({tag, "_addr"},   {16'b0, imem_addr},   32'h0000);
    chk({tag, "_valid"},  {31'b0, instr_valid}, 32'd0);
    chk({tag, "_instr"},  {16'b0, instr},       32'h0000);
    chk({tag, "_ipc"},    {16'b0, instr_pc},    32'h0000);
    chk({tag, "_halted"}, {31'b0, halted},      32'd0);
  endtask

  // Deassert reset, then expect one idle cycle followed by a request at 0.
  task automatic release_reset(input string tag);
    rst = 1'b0;
    chk({tag, "_idle_req"}, {31'b0, imem_req}, 32'd0);
    step();
    chk({tag, "_first_req"},  {31'b0, imem_req}, 32'd1);
    chk({tag, "_first_addr"}, {16'b0, imem_addr}, 32'h0000);
    exp_pc = 16'h0000;
  endtask

  // One fetch transaction, starting with the unit requesting at exp_pc.
  // ack_dly idle cycles before the ack, rdy_dly stall cycles in hold; a
  // stray ack during hold must be ignored. If br_hold, the held instruction
  // is dropped by a branch coincident with the accept.
  task automatic fetch(input int ack_dly, input int rdy_dly, input logic [15:0] data,
                       input bit br_hold, input logic [15:0] tgt);
    logic [15:0] addr;
    addr = exp_pc;
    chk("req_start", {31'b0, imem_req}, 32'd1);
    chk("addr_start", {16'b0, imem_addr}, {16'b0, addr});
    for (int i = 0; i < ack_dly; i++) begin
      step();
      chk("req_wait", {31'b0, imem_req}, 32'd1);
      chk("addr_wait", {16'b0, imem_addr}, {16'b0, addr});
    end
    imem_ack  = 1'b1;
    imem_data = data;
    step();
    imem_ack  = 1'b0;
    imem_data = $urandom_range(0, 16'hFFFF);
    chk("valid_rise", {31'b0, instr_valid}, 32'd1);
    chk("instr", {16'b0, instr}, {16'b0, data});
    chk("instr_pc", {16'b0, instr_pc}, {16'b0, addr});
    chk("req_in_hold", {31'b0, imem_req}, 32'd0);
    exp_pc = addr + 16'd1;
    for (int i = 0; i < rdy_dly; i++) begin
      imem_ack = $urandom_range(0, 1);
      step();
      chk("hold_valid", {31'b0, instr_valid}, 32'd1);
      chk("hold_instr", {16'b0, instr}, {16'b0, data});
      chk("hold_ipc", {16'b0, instr_pc}, {16'b0, addr});
      chk("hold_noreq", {31'b0, imem_req}, 32'd0);
    end
    imem_ack    = 1'b0;
    instr_ready = 1'b1;
    if (br_hold) begin
      br_taken  = 1'b1;
      br_target = tgt;
    end
    step();
    instr_ready = 1'b0;
    br_taken    = 1'b0;
    chk("accept_valid", {31'b0, instr_valid}, 32'd0);
    if (br_hold) begin
      chk("brh_idle_req", {31'b0, imem_req}, 32'd0);
      chk("brh_halted", {31'b0, halted}, 32'd0);
      step();
      chk("brh_req", {31'b0, imem_req}, 32'd1);
      chk("brh_addr", {16'b0, imem_addr}, {16'b0, tgt});
      exp_pc = tgt;
    end else if (data[15:12] == 4'hF) begin
      chk("halt_flag", {31'b0, halted}, 32'd1);
      chk("halt_noreq", {31'b0, imem_req}, 32'd0);
    end else begin
      chk("next_halted", {31'b0, halted}, 32'd0);
      chk("next_req", {31'b0, imem_req}, 32'd1);
      chk("next_addr", {16'b0, imem_addr}, {16'b0, exp_pc});
    end
  endtask

  // Branch while requesting, optionally with a coincident ack that must be discarded.
  task automatic branch_in_req(input logic [15:0] tgt, input bit with_ack);
    chk("br_req", {31'b0, imem_req}, 32'd1);
    br_taken  = 1'b1;
    br_target = tgt;
    imem_ack  = with_ack;
    imem_data = 16'hDEAD;
    step();
    br_taken = 1'b0;
    imem_ack = 1'b0;
    chk("br_valid", {31'b0, instr_valid}, 32'd0);
    chk("br_idle_req", {31'b0, imem_req}, 32'd0);
    step();
    chk("br_new_req", {31'b0, imem_req}, 32'd1);
    chk("br_new_addr", {16'b0, imem_addr}, {16'b0, tgt});
    exp_pc = tgt;
  endtask

  initial begin
    exp_pc = 16'h0000;
    // Reset values while reset is held.
    step();
    check_reset_vals("rst0");
    step();
    release_reset("rel0");

    // Second instance: boot address 0xFFFF wraps to 0x0000.
    chk("top_req", {31'b0, imem_req2}, 32'd1);
    chk("top_addr", {16'b0, imem_addr2}, 32'hFFFF);
    imem_ack2  = 1'b1;
    imem_data2 = 16'h1234;
    step();
    imem_ack2 = 1'b0;
    chk("top_ipc", {16'b0, instr_pc2}, 32'hFFFF);
    chk("top_valid", {31'b0, instr_valid2}, 32'd1);
    instr_ready2 = 1'b1;
    step();
    instr_ready2 = 1'b0;
    chk("top_wrap_req", {31'b0, imem_req2}, 32'd1);
    chk("top_wrap_addr", {16'b0, imem_addr2}, 32'h0000);

    // Streaming fetches, ack and accept every cycle: addresses 0..4.
    for (int i = 0; i < 5; i++) begin
      fetch(0, 0, 16'h1000 + exp_pc, 1'b0, 16'h0);
    end
    // Delayed ack at address 5.
    chk("addr5", {16'b0, exp_pc}, 32'h0005);
    fetch(3, 0, 16'h1005, 1'b0, 16'h0);
    // Decode stall of four cycles.
    fetch(0, 4, 16'h2222, 1'b0, 16'h0);
    // Branch coincident with ack.
    branch_in_req(16'h0040, 1'b1);
    fetch(1, 1, 16'h3040, 1'b0, 16'h0);
    // Branch coincident with accept drops the held instruction.
    fetch(0, 2, 16'h3041, 1'b1, 16'h0100);

    // Randomized transaction stream.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 7) == 0) begin
        branch_in_req(16'($urandom_range(0, 16'hFFFF)), 1'($urandom_range(0, 1)));
      end else begin
        fetch($urandom_range(0, 3), $urandom_range(0, 3),
              16'($urandom_range(0, 16'hEFFF)), ($urandom_range(0, 9) == 0),
              16'($urandom_range(0, 16'hFFFF)));
      end
    end

    // Asynchronous reset in the middle of hold.
    chk("pre_hold_req", {31'b0, imem_req}, 32'd1);
    imem_ack  = 1'b1;
    imem_data = 16'h5A5A;
    step();
    imem_ack = 1'b0;
    chk("mid_hold_valid", {31'b0, instr_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("rst_hold");
    step();
    release_reset("rel1");

    // Fetch HALT, then branches and acks are ignored.
    fetch(0, 1, 16'hF000, 1'b0, 16'h0);
    br_taken  = 1'b1;
    br_target = 16'h0077;
    imem_ack  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halt_stay", {31'b0, halted}, 32'd1);
      chk("halt_req0", {31'b0, imem_req}, 32'd0);
      chk("halt_valid0", {31'b0, instr_valid}, 32'd0);
    end
    br_taken = 1'b0;
    imem_ack = 1'b0;
    // Asynchronous reset from HALTED.
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("rst_halt");
    step();
    release_reset("rel2");
    fetch(0, 0, 16'h0ABC, 1'b0, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter WIDTH, default 16, shall set the data/address width of PC, IMEM and INSTR buses.
REQ-002 Parameter RESET_PC, default 16'h0000, shall set the PC value loaded on reset.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 BR_TAKEN  input  1  redirect request from execute stage.
REQ-006 BR_TARGET  input  WIDTH  redirect address, sampled when BR_TAKEN=1.
REQ-007 IMEM_REQ  output  1  instruction memory read request.
REQ-008 IMEM_ADDR  output  WIDTH  read address, equals PC.
REQ-009 IMEM_ACK  input  1  memory returns IMEM_DATA this cycle.
REQ-010 IMEM_DATA  input  WIDTH  instruction word, valid when IMEM_ACK=1.
REQ-011 INSTR  output  WIDTH  fetched instruction to decode.
REQ-012 INSTR_PC  output  WIDTH  address of INSTR.
REQ-013 INSTR_VALID  output  1  INSTR/INSTR_PC valid for decode.
REQ-014 INSTR_READY  input  1  decode accepts INSTR this cycle.
REQ-015 HALTED  output  1  fetch stopped after a HALT instruction was accepted.

Function
REQ-016 States shall be IDLE, REQ, HOLD, HALTED.
REQ-017 IDLE: IMEM_REQ=0, INSTR_VALID=0; next state REQ unconditionally.
REQ-018 REQ: IMEM_REQ=1, IMEM_ADDR=PC held stable until IMEM_ACK or BR_TAKEN.
REQ-019 REQ with IMEM_ACK=1: register INSTR<=IMEM_DATA, INSTR_PC<=PC, INSTR_VALID<=1, PC<=PC+1 (modulo 2^WIDTH, 16'hFFFF wraps to 16'h0000), next state HOLD.
REQ-020 Latency: INSTR_VALID shall rise on the edge that samples IMEM_ACK=1 (visible the cycle after ACK).
REQ-021 HOLD: INSTR_VALID=1, INSTR and INSTR_PC stable while INSTR_READY=0.
REQ-022 HOLD with INSTR_READY=1: INSTR_VALID<=0; next state HALTED if INSTR[15:12]==OP_HALT, else REQ.
REQ-023 BR_TAKEN=1 in IDLE, REQ or HOLD: PC<=BR_TARGET, INSTR_VALID<=0, next state IDLE; any IMEM_ACK or INSTR_READY in the same cycle shall be ignored (fetched data discarded, held instruction dropped).
REQ-024 Priority: RST > BR_TAKEN > IMEM_ACK / INSTR_READY.
REQ-025 HALTED: IMEM_REQ=0, INSTR_VALID=0, HALTED=1; BR_TAKEN ignored; only RST exits.
REQ-026 IMEM_ACK outside REQ shall be ignored.
REQ-027 HALTED shall be 0 in all states except HALTED.

Reset
REQ-028 RST=1 shall immediately force state IDLE, PC=RESET_PC, INSTR=0, INSTR_PC=0, INSTR_VALID=0, IMEM_REQ=0, HALTED=0, regardless of CLK, including mid-request.
REQ-029 First IMEM_REQ after RST deassertion shall assert in the second cycle (IDLE then REQ), with IMEM_ADDR=RESET_PC.

Structure
REQ-030 Shared package cpu_pkg shall hold WIDTH default, OP_HALT (4'hF) and the fetch state encoding.
REQ-031 PC storage shall be sub-module pc_reg: WIDTH-bit register, async active-high reset to RESET_PC, load enable, with next-PC chosen between PC+1 and BR_TARGET by the existing 2-to-1 selection.

Verification
REQ-032 Reset then IMEM_ACK=1 every cycle, INSTR_READY=1, data 16'h1000+addr -> IMEM_ADDR sequence 0,1,2,...; INSTR_PC matches; one instruction per 2 cycles after first.
REQ-033 IMEM_ACK delayed 3 cycles at addr 0x0005 -> IMEM_REQ held, IMEM_ADDR=0x0005 stable throughout; INSTR=data at ACK.
REQ-034 INSTR_READY=0 for 4 cycles in HOLD -> INSTR/INSTR_PC/INSTR_VALID unchanged; no new IMEM_REQ until accept.
REQ-035 BR_TAKEN=1, BR_TARGET=0x0040 coincident with IMEM_ACK -> data discarded, INSTR_VALID=0, next IMEM_ADDR=0x0040 after one IDLE cycle.
REQ-036 Start with RESET_PC=16'hFFFF -> INSTR_PC=0xFFFF then next IMEM_ADDR=0x0000.
REQ-037 Fetch 16'hF000 and accept -> HALTED=1, IMEM_REQ=0, BR_TAKEN ignored; RST mid-HOLD and in HALTED -> all outputs return to reset values at once.
